xi_mem_arbiter: RTL and testbench

Shares the single-read/single-write graph memory between N_CORES reduction cores. Each memory port has an independent round-robin arbiter. Read responses return to the issuing core using an in-flight tag pipeline. It sits between the core array and the graph memory in the multi-core Xi top level.

---
 rtl/xi_arb_pkg.sv | 41 ++++
 rtl/xi_mem_arbiter_if.sv | 40 ++++
 rtl/xi_rr_arbiter.sv | 37 +++
 rtl/xi_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_xi_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xi_arb_pkg.sv
// rtl/xi_arb_pkg.sv - shared constants and round-robin pick helper for the graph memory arbiter
package xi_arb_pkg;

    // Widest core array the pick helper is sized for
    localparam int MAX_CORES = 16;

    // Cycles from grant to read data at the cores
    localparam int RD_LATENCY = 2;

    // Core index width, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot pick of the first requester at or after ptr, wrapping modulo n
    function automatic logic [MAX_CORES-1:0] rr_pick(
        input logic [MAX_CORES-1:0] req,
        input int                   ptr,
        input int                   n
    );
        logic [MAX_CORES-1:0] gnt;
        logic                 found;
        int                   idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_CORES; k++) begin
            if (!found && (k < n)) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/xi_mem_arbiter_if.sv
// rtl/xi_mem_arbiter_if.sv - core-side and memory-side signal bundle of the graph memory arbiter
interface xi_mem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int NODE_W  = 160
);
    logic [N_CORES-1:0]        core_rd_req;
    logic [N_CORES*ADDR_W-1:0] core_rd_addr;
    logic [N_CORES-1:0]        core_rd_gnt;
    logic [N_CORES-1:0]        core_rd_valid;
    logic [NODE_W-1:0]         core_rd_data;
    logic [N_CORES-1:0]        core_wr_req;
    logic [N_CORES*ADDR_W-1:0] core_wr_addr;
    logic [N_CORES*NODE_W-1:0] core_wr_data;
    logic [N_CORES-1:0]        core_wr_gnt;
    logic                      mem_rd_en;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic                      mem_rd_valid;
    logic [NODE_W-1:0]         mem_rd_data;
    logic                      mem_wr_en;
    logic [ADDR_W-1:0]         mem_wr_addr;
    logic [NODE_W-1:0]         mem_wr_data;
    logic                      err_stray;

    // Arbiter view
    modport slave (
        input  core_rd_req, core_rd_addr, core_wr_req, core_wr_addr, core_wr_data,
        input  mem_rd_valid, mem_rd_data,
        output core_rd_gnt, core_rd_valid, core_rd_data, core_wr_gnt,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, err_stray
    );

    // Core array plus memory view
    modport master (
        output core_rd_req, core_rd_addr, core_wr_req, core_wr_addr, core_wr_data,
        output mem_rd_valid, mem_rd_data,
        input  core_rd_gnt, core_rd_valid, core_rd_data, core_wr_gnt,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, err_stray
    );
endinterface

// File: rtl/xi_rr_arbiter.sv
// rtl/xi_rr_arbiter.sv - round-robin arbiter with combinational one-hot grant and rotating pointer
module xi_rr_arbiter
    import xi_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Grant the first requester at or after the pointer; move the pointer past the winner
    always_comb begin
        gnt   = N'(rr_pick(MAX_CORES'(req), int'(ptr_q), N));
        ptr_d = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                ptr_d = (i == N - 1) ? '0 : IDX_W'(i + 1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xi_mem_arbiter.sv
// rtl/xi_mem_arbiter.sv - shares the graph memory read/write ports among cores; XI_ARB_STATS_EN adds arb_stall_cnt
module xi_mem_arbiter
    import xi_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int NODE_W  = 160
) (
    input  logic             clk,
    input  logic             rst_n,
    xi_mem_arbiter_if.slave  bus
`ifdef XI_ARB_STATS_EN
    ,
    output logic [31:0]      arb_stall_cnt
`endif
);

    localparam int IDX_W = idx_width(N_CORES);

    logic [N_CORES-1:0] rd_gnt;
    logic [N_CORES-1:0] wr_gnt;

    logic [ADDR_W-1:0]  rd_sel_addr;
    logic [IDX_W-1:0]   rd_sel_tag;
    logic [ADDR_W-1:0]  wr_sel_addr;
    logic [NODE_W-1:0]  wr_sel_data;

    logic [ADDR_W-1:0]  mem_rd_addr_q, mem_rd_addr_d;
    logic               mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0]  mem_wr_addr_q, mem_wr_addr_d;
    logic [NODE_W-1:0]  mem_wr_data_q, mem_wr_data_d;
    logic               err_stray_q, err_stray_d;

    // Tag pipeline: stage 0 is the cycle mem_rd_en is high, last stage lines up with mem_rd_valid
    logic [RD_LATENCY-1:0]            rd_pipe_vld_q, rd_pipe_vld_d;
    logic [RD_LATENCY-1:0][IDX_W-1:0] rd_pipe_tag_q, rd_pipe_tag_d;

    logic rsp_hit;

    xi_rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.core_rd_req),
        .gnt   (rd_gnt)
    );

    xi_rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.core_wr_req),
        .gnt   (wr_gnt)
    );

    // Mux the winning core's address/data and tag onto the memory side
    always_comb begin
        rd_sel_addr = '0;
        rd_sel_tag  = '0;
        wr_sel_addr = '0;
        wr_sel_data = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (rd_gnt[i]) begin
                rd_sel_addr = bus.core_rd_addr[i*ADDR_W +: ADDR_W];
                rd_sel_tag  = IDX_W'(i);
            end
            if (wr_gnt[i]) begin
                wr_sel_addr = bus.core_wr_addr[i*ADDR_W +: ADDR_W];
                wr_sel_data = bus.core_wr_data[i*NODE_W +: NODE_W];
            end
        end
    end

    // Next state for memory command registers, tag pipeline and stray flag
    always_comb begin
        mem_rd_addr_d    = rd_sel_addr;
        mem_wr_en_d      = |wr_gnt;
        mem_wr_addr_d    = wr_sel_addr;
        mem_wr_data_d    = wr_sel_data;
        rd_pipe_vld_d    = '0;
        rd_pipe_tag_d    = '0;
        rd_pipe_vld_d[0] = |rd_gnt;
        rd_pipe_tag_d[0] = rd_sel_tag;
        for (int k = 1; k < RD_LATENCY; k++) begin
            rd_pipe_vld_d[k] = rd_pipe_vld_q[k-1];
            rd_pipe_tag_d[k] = rd_pipe_tag_q[k-1];
        end
        err_stray_d = err_stray_q | (bus.mem_rd_valid & ~rd_pipe_vld_q[RD_LATENCY-1]);
    end

    // Registered memory command, tag pipeline and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_addr_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            rd_pipe_vld_q <= '0;
            rd_pipe_tag_q <= '0;
            err_stray_q   <= 1'b0;
        end else begin
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            rd_pipe_vld_q <= rd_pipe_vld_d;
            rd_pipe_tag_q <= rd_pipe_tag_d;
            err_stray_q   <= err_stray_d;
        end
    end

    // Route returning data to the core whose tag reached the end of the pipeline
    always_comb begin
        rsp_hit           = bus.mem_rd_valid & rd_pipe_vld_q[RD_LATENCY-1];
        bus.core_rd_valid = rsp_hit ? (N_CORES'(1) << rd_pipe_tag_q[RD_LATENCY-1]) : '0;
        bus.core_rd_data  = rsp_hit ? bus.mem_rd_data : '0;
    end

    assign bus.core_rd_gnt = rd_gnt;
    assign bus.core_wr_gnt = wr_gnt;
    assign bus.mem_rd_en   = rd_pipe_vld_q[0];
    assign bus.mem_rd_addr = mem_rd_addr_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_wr_addr = mem_wr_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.err_stray   = err_stray_q;

`ifdef XI_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // Count cycles where some core on either port is left waiting, saturating at all-ones
    always_comb begin
        stall       = (|(bus.core_rd_req & ~rd_gnt)) | (|(bus.core_wr_req & ~wr_gnt));
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign arb_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_xi_mem_arbiter.sv
// tb/tb_xi_mem_arbiter.sv - directed self-checking bench for xi_mem_arbiter
module tb_xi_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int NW = 160;

    logic clk;
    logic rst_n;
    logic stray_inj;
    logic          mdl_rd_valid;
    logic [NW-1:0] mdl_rd_data;
    logic [NW-1:0] mem [0:4095];
`ifdef XI_ARB_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int checks;
    int errors;

    xi_mem_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .NODE_W(NW)) bus ();

    xi_mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .NODE_W(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef XI_ARB_STATS_EN
        ,
        .arb_stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-before-write memory model with one cycle read latency
    always @(posedge clk) begin
        mdl_rd_valid <= bus.mem_rd_en;
        if (bus.mem_rd_en) begin
            mdl_rd_data <= mem[bus.mem_rd_addr];
        end
        if (bus.mem_wr_en) begin
            mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
    end

    assign bus.mem_rd_valid = mdl_rd_valid | stray_inj;
    assign bus.mem_rd_data  = mdl_rd_data;

    function automatic logic [NW-1:0] pat(input logic [AW-1:0] a);
        return {148'h5A5A_0000_1234, a};
    endfunction

    task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_rd_req  = '0;
        bus.core_wr_req  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        stray_inj       = 1'b0;
        mdl_rd_valid    = 1'b0;
        mdl_rd_data     = '0;
        bus.core_rd_addr = '0;
        bus.core_wr_addr = '0;
        bus.core_wr_data = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = pat(AW'(i));
        end
        do_reset();

        // Reset state: ten idle cycles, everything quiet
        for (int c = 0; c < 10; c++) begin
            cyc();
            settle();
            check("rst_rd_gnt", NW'(bus.core_rd_gnt), '0);
            check("rst_wr_gnt", NW'(bus.core_wr_gnt), '0);
            check("rst_rd_en", NW'(bus.mem_rd_en), '0);
            check("rst_wr_en", NW'(bus.mem_wr_en), '0);
            check("rst_rd_valid", NW'(bus.core_rd_valid), '0);
            check("rst_err", NW'(bus.err_stray), '0);
        end

        // Single reader: core 2 reads 12'h05A
        cyc();
        bus.core_rd_req = 4'b0100;
        bus.core_rd_addr[2*AW +: AW] = 12'h05A;
        settle();
        check("single_gnt", NW'(bus.core_rd_gnt), NW'(4'b0100));
        cyc();
        bus.core_rd_req = '0;
        settle();
        check("single_rd_en", NW'(bus.mem_rd_en), NW'(1'b1));
        check("single_rd_addr", NW'(bus.mem_rd_addr), NW'(12'h05A));
        check("single_early_valid", NW'(bus.core_rd_valid), '0);
        cyc();
        settle();
        check("single_valid", NW'(bus.core_rd_valid), NW'(4'b0100));
        check("single_data", bus.core_rd_data, pat(12'h05A));
        check("single_rd_en_off", NW'(bus.mem_rd_en), '0);

        // Fairness: all four cores hold requests for eight cycles
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.core_rd_addr[i*AW +: AW] = AW'(12'h100 + i);
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            bus.core_rd_req = (k < 8) ? 4'b1111 : 4'b0000;
            settle();
            if (k < 8) begin
                check("fair_gnt", NW'(bus.core_rd_gnt), NW'(4'b0001 << (k % 4)));
            end
            if (k >= 2) begin
                check("fair_valid", NW'(bus.core_rd_valid), NW'(4'b0001 << ((k - 2) % 4)));
                check("fair_data", bus.core_rd_data, pat(AW'(12'h100 + ((k - 2) % 4))));
            end else begin
                check("fair_valid_none", NW'(bus.core_rd_valid), '0);
            end
        end
        cyc();
        bus.core_rd_req = '0;

        // Concurrent ports: core 1 writes 7 to 12'h010 while core 3 reads it
        cyc();
        bus.core_wr_req = 4'b0010;
        bus.core_wr_addr[1*AW +: AW] = 12'h010;
        bus.core_wr_data[1*NW +: NW] = NW'(64'd7);
        bus.core_rd_req = 4'b1000;
        bus.core_rd_addr[3*AW +: AW] = 12'h010;
        settle();
        check("conc_wr_gnt", NW'(bus.core_wr_gnt), NW'(4'b0010));
        check("conc_rd_gnt", NW'(bus.core_rd_gnt), NW'(4'b1000));
        cyc();
        idle_inputs();
        settle();
        check("conc_wr_en", NW'(bus.mem_wr_en), NW'(1'b1));
        check("conc_wr_addr", NW'(bus.mem_wr_addr), NW'(12'h010));
        check("conc_wr_data", bus.mem_wr_data, NW'(64'd7));
        check("conc_rd_en", NW'(bus.mem_rd_en), NW'(1'b1));
        check("conc_rd_addr", NW'(bus.mem_rd_addr), NW'(12'h010));
        cyc();
        settle();
        check("conc_rd_valid", NW'(bus.core_rd_valid), NW'(4'b1000));
        check("conc_rd_old", bus.core_rd_data, pat(12'h010));

        // Continuous single writer (core 0) granted every cycle, plus re-read of 12'h010 by core 0
        bus.core_wr_addr[0*AW +: AW] = 12'h020;
        bus.core_wr_data[0*NW +: NW] = NW'(64'd99);
        bus.core_rd_addr[0*AW +: AW] = 12'h010;
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.core_wr_req = 4'b0001;
            bus.core_rd_req = (k == 0) ? 4'b0001 : 4'b0000;
            settle();
            check("cont_wr_gnt", NW'(bus.core_wr_gnt), NW'(4'b0001));
            if (k == 0) begin
                check("reread_gnt", NW'(bus.core_rd_gnt), NW'(4'b0001));
            end
            if (k == 2) begin
                check("reread_valid", NW'(bus.core_rd_valid), NW'(4'b0001));
                check("reread_new", bus.core_rd_data, NW'(64'd7));
            end
        end
        cyc();
        idle_inputs();
        cyc();

        // Reset mid-flight: core 1 read and core 2 write granted, reset in T+1
        cyc();
        bus.core_rd_req = 4'b0010;
        bus.core_rd_addr[1*AW +: AW] = 12'h0AA;
        bus.core_wr_req = 4'b0100;
        bus.core_wr_addr[2*AW +: AW] = 12'h0BB;
        settle();
        check("mid_rd_gnt", NW'(bus.core_rd_gnt), NW'(4'b0010));
        check("mid_wr_gnt", NW'(bus.core_wr_gnt), NW'(4'b0100));
        cyc();
        idle_inputs();
        rst_n = 1'b0;
        settle();
        check("mid_rd_en_clr", NW'(bus.mem_rd_en), '0);
        check("mid_wr_en_clr", NW'(bus.mem_wr_en), '0);
        cyc();
        stray_inj = 1'b1;
        settle();
        check("mid_no_valid", NW'(bus.core_rd_valid), '0);
        cyc();
        stray_inj = 1'b0;
        rst_n = 1'b1;
        settle();
        check("mid_no_valid2", NW'(bus.core_rd_valid), '0);
        check("mid_err_clear", NW'(bus.err_stray), '0);
        cyc();
        bus.core_rd_req = 4'b1111;
        bus.core_wr_req = 4'b1111;
        settle();
        check("mid_rd_ptr0", NW'(bus.core_rd_gnt), NW'(4'b0001));
        check("mid_wr_ptr0", NW'(bus.core_wr_gnt), NW'(4'b0001));
        cyc();
        idle_inputs();
        cyc();
        cyc();
        cyc();

        // Stray response: valid with nothing in flight
        cyc();
        stray_inj = 1'b1;
        settle();
        check("stray_no_valid", NW'(bus.core_rd_valid), '0);
        check("stray_err_pre", NW'(bus.err_stray), '0);
        cyc();
        stray_inj = 1'b0;
        settle();
        check("stray_err_set", NW'(bus.err_stray), NW'(1'b1));
        for (int c = 0; c < 3; c++) begin
            cyc();
            settle();
            check("stray_err_sticky", NW'(bus.err_stray), NW'(1'b1));
            check("stray_no_valid2", NW'(bus.core_rd_valid), '0);
        end
        cyc();
        rst_n = 1'b0;
        settle();
        check("stray_err_reset", NW'(bus.err_stray), '0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
